// File: rtl/button_event_ctrl.sv
// Turns the debounced button level into short / long / auto-repeat event pulses.
// All outputs are registered; a db_sig sample at edge k shows up right after edge k.
module button_event_ctrl #(
   parameter int unsigned LONG_CYCLES   = 8,
   parameter int unsigned REPEAT_CYCLES = 4,
   parameter int unsigned CNT_W         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       db_sig,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      ARM     = 2'b00,
      IDLE    = 2'b01,
      PRESSED = 2'b10,
      REPEAT  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             short_nx, long_nx, repeat_nx, held_nx;
   logic [7:0]       press_count_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ARM;
         cnt          <= '0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         held         <= 1'b0;
         press_count  <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         short_pulse  <= short_nx;
         long_pulse   <= long_nx;
         repeat_pulse <= repeat_nx;
         held         <= held_nx;
         press_count  <= press_count_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      short_nx       = 1'b0;
      long_nx        = 1'b0;
      repeat_nx      = 1'b0;
      press_count_nx = press_count;

      case (state)
         // A button held through reset must be released once before it counts.
         ARM: begin
            if (!db_sig) state_nx = IDLE;
         end
         IDLE: begin
            if (db_sig) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end
         end
         PRESSED: begin
            // Release wins over the limit compare: a release on the limit edge is still short.
            if (!db_sig) begin
               state_nx       = IDLE;
               short_nx       = 1'b1;
               press_count_nx = press_count + 8'd1;
            end else if (cnt == LONG_LAST) begin
               state_nx       = REPEAT;
               long_nx        = 1'b1;
               press_count_nx = press_count + 8'd1;
               cnt_nx         = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         REPEAT: begin
            if (!db_sig) begin
               state_nx = IDLE;
            end else if (cnt == REPEAT_LAST) begin
               repeat_nx = 1'b1;
               cnt_nx    = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = ARM;
            cnt_nx   = '0;
         end
      endcase

      held_nx = (state_nx == PRESSED) || (state_nx == REPEAT);
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with default parameters (LONG=8, REPEAT=4).
module tb_button_event_ctrl;

   logic       clk;
   logic       reset;
   logic       db_sig;
   logic       short_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       held;
   logic [7:0] press_count;

   int total;
   int bad;

   button_event_ctrl #(
      .LONG_CYCLES   (8),
      .REPEAT_CYCLES (4),
      .CNT_W         (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .db_sig       (db_sig),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic rst, input logic d);
      @(negedge clk);
      reset  = rst;
      db_sig = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input int s, input int l, input int r,
                             input int h, input int pc);
      check({tag, ".short"},  int'(short_pulse),  s);
      check({tag, ".long"},   int'(long_pulse),   l);
      check({tag, ".repeat"}, int'(repeat_pulse), r);
      check({tag, ".held"},   int'(held),         h);
      check({tag, ".count"},  int'(press_count),  pc);
   endtask

   initial begin
      int shorts;
      total  = 0;
      bad    = 0;
      reset  = 1'b1;
      db_sig = 1'b0;

      // T1: reset, then one idle cycle
      step(1'b1, 1'b0);
      check_outs("t1_reset", 0, 0, 0, 0, 0);
      step(1'b0, 1'b0);
      check_outs("t1_idle", 0, 0, 0, 0, 0);

      // T2: press e0..e3, release at e4
      step(1'b0, 1'b1);
      check_outs("t2_e0", 0, 0, 0, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b1);
         check_outs("t2_hold", 0, 0, 0, 1, 0);
      end
      step(1'b0, 1'b0);
      check_outs("t2_e4", 1, 0, 0, 0, 1);
      step(1'b0, 1'b0);
      check_outs("t2_after", 0, 0, 0, 0, 1);

      // T3: continuous hold: long at e8, repeats at e12, e16, e20
      for (int i = 0; i <= 22; i++) begin
         step(1'b0, 1'b1);
         check_outs($sformatf("t3_e%0d", i), 0, (i == 8) ? 1 : 0,
                    (i == 12 || i == 16 || i == 20) ? 1 : 0, 1, (i >= 8) ? 2 : 1);
      end
      step(1'b0, 1'b0);
      check_outs("t3_release", 0, 0, 0, 0, 2);

      // T4: release on the edge the count would reach the limit -> short
      for (int i = 0; i <= 7; i++) begin
         step(1'b0, 1'b1);
         check_outs($sformatf("t4_e%0d", i), 0, 0, 0, 1, 2);
      end
      step(1'b0, 1'b0);
      check_outs("t4_e8", 1, 0, 0, 0, 3);

      // T5: button held through reset stays silent until released once
      step(1'b1, 1'b1);
      check_outs("t5_reset", 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1);
         check_outs("t5_armhold", 0, 0, 0, 0, 0);
      end
      step(1'b0, 1'b0);
      check_outs("t5_rel", 0, 0, 0, 0, 0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check_outs("t5_press", 0, 0, 0, 1, 0);
      step(1'b0, 1'b0);
      check_outs("t5_short", 1, 0, 0, 0, 1);

      // T6: reset mid-press aborts without a pulse, lands in ARM
      for (int i = 0; i <= 4; i++) step(1'b0, 1'b1);
      check_outs("t6_prereset", 0, 0, 0, 1, 1);
      step(1'b1, 1'b1);
      check_outs("t6_reset", 0, 0, 0, 0, 0);
      step(1'b0, 1'b1);
      check_outs("t6_arm", 0, 0, 0, 0, 0);
      step(1'b0, 1'b0);

      // 256 short presses wrap press_count back to 0
      shorts = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b0, 1'b1);
         step(1'b0, 1'b0);
         if (short_pulse) shorts++;
         if (i == 254) check("t6_count255", int'(press_count), 255);
      end
      check("t6_shorts", shorts, 256);
      check_outs("t6_wrap", 1, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
